sdram_cmd_queue: RTL and testbench

SDRAM_CMD_QUEUE -- requirements
Module: sdram_cmd_queue

---
 rtl/sdram_pkg.sv | 19 +
 rtl/sdram_cmd_queue_if.sv | 25 ++
 rtl/sdram_cmd_fifo.sv | 58 +++++
 rtl/sdram_cmd_queue.sv | 134 +++++++++++++
 tb/tb_sdram_cmd_queue.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, FSM state enum and command record for the SDRAM command queue
package sdram_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WR = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/sdram_cmd_queue_if.sv
// rtl/sdram_cmd_queue_if.sv - push/pop stream bundle between the issue FSM and the command FIFO
interface sdram_cmd_queue_if #(
    parameter int DEPTH = 8
);
    import sdram_pkg::*;

    logic                   push_tvalid;
    logic                   push_tready;
    cmd_t                   push_tdata;
    logic                   pop_tvalid;
    logic                   pop_tready;
    cmd_t                   pop_tdata;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output push_tvalid, push_tdata, pop_tready,
        input  push_tready, pop_tvalid, pop_tdata, count
    );

    modport slave (
        input  push_tvalid, push_tdata, pop_tready,
        output push_tready, pop_tvalid, pop_tdata, count
    );

endinterface

// File: rtl/sdram_cmd_fifo.sv
// rtl/sdram_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module sdram_cmd_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic               iclk,
    input logic               ireset,
    sdram_cmd_queue_if.slave  fifo_if
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign fifo_if.push_tready = (count_q != FULL_COUNT);
    assign fifo_if.pop_tvalid  = (count_q != '0);
    assign fifo_if.pop_tdata   = mem_q[rd_ptr_q];
    assign fifo_if.count       = count_q;

    assign do_push = fifo_if.push_tvalid && fifo_if.push_tready;
    assign do_pop  = fifo_if.pop_tready  && fifo_if.pop_tvalid;

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge iclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= fifo_if.push_tdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count moves only on push-xor-pop.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// rtl/sdram_cmd_queue.sv - host command queue issuing one request at a time to an SDRAM controller
module sdram_cmd_queue
    import sdram_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   icmd_valid,
    output logic                   ocmd_ready,
    input  logic                   icmd_we,
    input  logic [ADDR_W-1:0]      icmd_address,
    input  logic [DATA_W-1:0]      icmd_wdata,
    output logic                   orsp_valid,
    output logic [DATA_W-1:0]      orsp_data,
    output logic                   owrite_req,
    output logic [ADDR_W-1:0]      owrite_address,
    output logic [DATA_W-1:0]      owrite_data,
    input  logic                   iwrite_ack,
    output logic                   oread_req,
    output logic [ADDR_W-1:0]      oread_address,
    input  logic [DATA_W-1:0]      iread_data,
    input  logic                   iread_ack,
    output logic [$clog2(DEPTH):0] ocount,
    output logic                   obusy,
    output logic                   oerror
);

    localparam int                TMR_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic              wr_req_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              error_q;

    sdram_cmd_queue_if #(.DEPTH(DEPTH)) fifo_if ();

    sdram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iclk    (iclk),
        .ireset  (ireset),
        .fifo_if (fifo_if.slave)
    );

    assign fifo_if.push_tvalid = icmd_valid;
    assign fifo_if.push_tdata  = cmd_t'{we: icmd_we, address: icmd_address, wdata: icmd_wdata};
    assign fifo_if.pop_tready  = (state_q == IDLE);

    assign ocmd_ready     = fifo_if.push_tready;
    assign ocount         = fifo_if.count;
    assign obusy          = (state_q != IDLE);
    assign owrite_req     = wr_req_q;
    assign owrite_address = wr_addr_q;
    assign owrite_data    = wr_data_q;
    assign oread_req      = rd_req_q;
    assign oread_address  = rd_addr_q;
    assign orsp_valid     = rsp_valid_q;
    assign orsp_data      = rsp_data_q;
    assign oerror         = error_q;

    // Issue FSM: pop the head in IDLE, hold the request until its own ack or the timeout.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fifo_if.pop_tvalid) begin
                        timer_q <= '0;
                        if (fifo_if.pop_tdata.we) begin
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= fifo_if.pop_tdata.address;
                            wr_data_q <= fifo_if.pop_tdata.wdata;
                            state_q   <= WAIT_WR;
                        end else begin
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= fifo_if.pop_tdata.address;
                            state_q   <= WAIT_RD;
                        end
                    end
                end
                WAIT_WR: begin
                    if (iwrite_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        wr_req_q <= 1'b0;
                        error_q  <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                WAIT_RD: begin
                    if (iread_ack) begin
                        rd_req_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= iread_data;
                        state_q     <= IDLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        rd_req_q <= 1'b0;
                        error_q  <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    wr_req_q <= 1'b0;
                    rd_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// tb/tb_sdram_cmd_queue.sv - self-checking bench for sdram_cmd_queue against a transaction-level model
module tb_sdram_cmd_queue;
    import sdram_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        iclk = 1'b0;
    logic        ireset, icmd_valid, icmd_we, iwrite_ack, iread_ack;
    logic [21:0] icmd_address;
    logic [15:0] icmd_wdata, iread_data;
    logic        ocmd_ready, orsp_valid, owrite_req, oread_req, obusy, oerror;
    logic [15:0] orsp_data, owrite_data;
    logic [21:0] owrite_address, oread_address;
    logic [3:0]  ocount;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transaction-level model: pending list, one outstanding command, last-issued values.
    cmd_t        m_q[$];
    logic        m_busy = 1'b0;
    cmd_t        m_cur  = '0;
    int          m_wait = 0;
    logic        m_err  = 1'b0;
    logic        m_rsp_v = 1'b0;
    logic [15:0] m_rsp_d = '0;
    logic [21:0] m_wa = '0;
    logic [15:0] m_wd = '0;
    logic [21:0] m_ra = '0;

    always #5 iclk = ~iclk;

    sdram_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .iclk(iclk), .ireset(ireset),
        .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready), .icmd_we(icmd_we),
        .icmd_address(icmd_address), .icmd_wdata(icmd_wdata),
        .orsp_valid(orsp_valid), .orsp_data(orsp_data),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .iwrite_ack(iwrite_ack),
        .oread_req(oread_req), .oread_address(oread_address),
        .iread_data(iread_data), .iread_ack(iread_ack),
        .ocount(ocount), .obusy(obusy), .oerror(oerror)
    );

    // Advance one clock and apply the same edge to the model; sampling happens #1 later.
    task automatic step();
        logic pop_now, acc, ack_ok;
        cmd_t new_cmd;
        pop_now = !m_busy && (m_q.size() > 0);
        acc     = icmd_valid && (m_q.size() != DEPTH);
        new_cmd = '{we: icmd_we, address: icmd_address, wdata: icmd_wdata};
        @(posedge iclk);
        ack_ok  = m_cur.we ? iwrite_ack : iread_ack;
        m_rsp_v = 1'b0;
        if (ireset) begin
            m_q.delete();
            m_busy = 1'b0; m_wait = 0; m_err = 1'b0; m_rsp_d = '0;
            m_wa = '0; m_wd = '0; m_ra = '0;
        end else begin
            if (m_busy) begin
                if (ack_ok) begin
                    m_busy = 1'b0;
                    if (!m_cur.we) begin m_rsp_v = 1'b1; m_rsp_d = iread_data; end
                end else if (m_wait + 1 == TIMEOUT) begin
                    m_busy = 1'b0; m_err = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            if (pop_now) begin
                m_cur = m_q.pop_front(); m_busy = 1'b1; m_wait = 0;
                if (m_cur.we) begin m_wa = m_cur.address; m_wd = m_cur.wdata; end
                else m_ra = m_cur.address;
            end
            if (acc) m_q.push_back(new_cmd);
        end
        #1;
    endtask

    task automatic set_cmd(input logic we, input logic [21:0] addr, input logic [15:0] data);
        icmd_valid = 1'b1; icmd_we = we; icmd_address = addr; icmd_wdata = data;
    endtask

    task automatic test_reset();
        ireset = 1'b1; step(); ireset = 1'b0;
        total_cnt++; if ({owrite_req, oread_req, orsp_valid, obusy, oerror} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {owrite_req, oread_req, orsp_valid, obusy, oerror}); else pass_cnt++;
        total_cnt++; if ({owrite_address, owrite_data, oread_address, orsp_data} !== 76'b0) $display("FAIL reset_buses: got %h want 0", {owrite_address, owrite_data, oread_address, orsp_data}); else pass_cnt++;
        total_cnt++; if (ocount !== 4'd0) $display("FAIL reset_count: got %0d want 0", ocount); else pass_cnt++;
        total_cnt++; if (ocmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ocmd_ready); else pass_cnt++;
    endtask

    task automatic test_single_write();
        set_cmd(1'b1, 22'h00_1234, 16'hA5A5); step(); icmd_valid = 1'b0;
        total_cnt++; if (ocount !== 4'd1 || owrite_req !== 1'b0) $display("FAIL wr_accept: got count=%0d req=%b want 1/0", ocount, owrite_req); else pass_cnt++;
        step();
        total_cnt++; if (owrite_req !== 1'b1 || oread_req !== 1'b0 || obusy !== 1'b1) $display("FAIL wr_issue: got wr=%b rd=%b busy=%b want 1/0/1", owrite_req, oread_req, obusy); else pass_cnt++;
        total_cnt++; if (owrite_address !== 22'h00_1234 || owrite_data !== 16'hA5A5) $display("FAIL wr_values: got %h/%h want 001234/a5a5", owrite_address, owrite_data); else pass_cnt++;
        iread_ack = 1'b1; repeat (3) step(); iread_ack = 1'b0;
        total_cnt++; if (owrite_req !== 1'b1 || owrite_address !== 22'h00_1234 || owrite_data !== 16'hA5A5) $display("FAIL wr_hold: got req=%b %h/%h want 1 001234/a5a5", owrite_req, owrite_address, owrite_data); else pass_cnt++;
        iwrite_ack = 1'b1; step(); iwrite_ack = 1'b0;
        total_cnt++; if (owrite_req !== 1'b0 || orsp_valid !== 1'b0 || obusy !== 1'b0) $display("FAIL wr_done: got req=%b rsp=%b busy=%b want 0/0/0", owrite_req, orsp_valid, obusy); else pass_cnt++;
    endtask

    task automatic test_single_read();
        set_cmd(1'b0, 22'h3F_FFFF, 16'h0000); step(); icmd_valid = 1'b0; step();
        total_cnt++; if (oread_req !== 1'b1 || owrite_req !== 1'b0 || oread_address !== 22'h3F_FFFF) $display("FAIL rd_issue: got rd=%b wr=%b addr=%h want 1/0/3fffff", oread_req, owrite_req, oread_address); else pass_cnt++;
        step();
        iread_data = 16'h5A5A; iread_ack = 1'b1; step(); iread_ack = 1'b0;
        total_cnt++; if (orsp_valid !== 1'b1 || orsp_data !== 16'h5A5A || oread_req !== 1'b0) $display("FAIL rd_rsp: got v=%b d=%h req=%b want 1/5a5a/0", orsp_valid, orsp_data, oread_req); else pass_cnt++;
        step();
        total_cnt++; if (orsp_valid !== 1'b0) $display("FAIL rd_pulse: got %b want 0", orsp_valid); else pass_cnt++;
    endtask

    task automatic test_full_queue();
        cmd_t exp[10];
        int   idx;
        for (int i = 0; i < 10; i++) exp[i] = '{we: i[0], address: 22'(32'h1000 + i * 7), wdata: 16'(16'hC000 + i)};
        exp[0].we = 1'b1;
        set_cmd(exp[0].we, exp[0].address, exp[0].wdata); step();
        for (int i = 1; i <= 8; i++) begin set_cmd(exp[i].we, exp[i].address, exp[i].wdata); step(); end
        total_cnt++; if (ocount !== 4'd8 || ocmd_ready !== 1'b0) $display("FAIL full_state: got count=%0d ready=%b want 8/0", ocount, ocmd_ready); else pass_cnt++;
        set_cmd(exp[9].we, exp[9].address, exp[9].wdata); step(); icmd_valid = 1'b0;
        total_cnt++; if (ocount !== 4'd8) $display("FAIL full_reject: got count=%0d want 8", ocount); else pass_cnt++;
        total_cnt++; if (owrite_req !== 1'b1 || owrite_address !== exp[0].address) $display("FAIL full_head: got req=%b addr=%h want 1/%h", owrite_req, owrite_address, exp[0].address); else pass_cnt++;
        iwrite_ack = 1'b1; step(); iwrite_ack = 1'b0;
        idx = 1;
        for (int cyc = 0; cyc < 200 && idx < 9; cyc++) begin
            if (owrite_req || oread_req) begin
                total_cnt++;
                if (owrite_req !== exp[idx].we || (exp[idx].we ? owrite_address : oread_address) !== exp[idx].address)
                    $display("FAIL full_order[%0d]: got wr=%b addr=%h want we=%b addr=%h", idx, owrite_req, exp[idx].we ? owrite_address : oread_address, exp[idx].we, exp[idx].address);
                else pass_cnt++;
                iwrite_ack = owrite_req; iread_ack = oread_req; step(); iwrite_ack = 1'b0; iread_ack = 1'b0;
                idx++;
            end else step();
        end
        total_cnt++; if (idx !== 9 || ocount !== 4'd0) $display("FAIL full_drain: got issued=%0d count=%0d want 9/0", idx, ocount); else pass_cnt++;
    endtask

    task automatic test_push_pop();
        int served;
        set_cmd(1'b1, 22'h00_0A00, 16'h1111); step();
        for (int i = 0; i < 3; i++) begin set_cmd(1'b1, 22'(22'h00_0A01 + i), 16'(16'h2220 + i)); step(); end
        icmd_valid = 1'b0;
        total_cnt++; if (ocount !== 4'd3 || obusy !== 1'b1) $display("FAIL pp_fill: got count=%0d busy=%b want 3/1", ocount, obusy); else pass_cnt++;
        iwrite_ack = 1'b1; step(); iwrite_ack = 1'b0;
        set_cmd(1'b0, 22'h00_0B00, 16'h0000); step(); icmd_valid = 1'b0;
        total_cnt++; if (ocount !== 4'd3 || owrite_req !== 1'b1 || owrite_address !== 22'h00_0A01) $display("FAIL pp_same_edge: got count=%0d req=%b addr=%h want 3/1/000a01", ocount, owrite_req, owrite_address); else pass_cnt++;
        served = 0;
        for (int cyc = 0; cyc < 100 && served < 4; cyc++) begin
            if (owrite_req || oread_req) begin
                iwrite_ack = owrite_req; iread_ack = oread_req; step(); iwrite_ack = 1'b0; iread_ack = 1'b0; served++;
            end else step();
        end
        total_cnt++; if (served !== 4 || ocount !== 4'd0) $display("FAIL pp_drain: got served=%0d count=%0d want 4/0", served, ocount); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cyc;
        total_cnt++; if (oerror !== 1'b0) $display("FAIL to_pre: got oerror=%b want 0", oerror); else pass_cnt++;
        set_cmd(1'b1, 22'h15_5555, 16'hBEEF); step();
        set_cmd(1'b0, 22'h2A_AAAA, 16'h0000); step(); icmd_valid = 1'b0;
        cyc = 0;
        while (owrite_req && cyc < 40) begin step(); cyc++; end
        total_cnt++; if (cyc !== TIMEOUT) $display("FAIL to_cycles: got %0d want %0d", cyc, TIMEOUT); else pass_cnt++;
        total_cnt++; if (oerror !== 1'b1 || orsp_valid !== 1'b0 || obusy !== 1'b0) $display("FAIL to_flags: got err=%b rsp=%b busy=%b want 1/0/0", oerror, orsp_valid, obusy); else pass_cnt++;
        step();
        total_cnt++; if (oread_req !== 1'b1 || oread_address !== 22'h2A_AAAA) $display("FAIL to_next: got req=%b addr=%h want 1/2aaaaa", oread_req, oread_address); else pass_cnt++;
        iread_data = 16'h0F0F; iread_ack = 1'b1; step(); iread_ack = 1'b0;
        total_cnt++; if (orsp_valid !== 1'b1 || orsp_data !== 16'h0F0F || oerror !== 1'b1) $display("FAIL to_after: got v=%b d=%h err=%b want 1/0f0f/1", orsp_valid, orsp_data, oerror); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] exp_cnt;
        ireset = 1'b1; step(); ireset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            set_cmd(1'($urandom), 22'($urandom), 16'($urandom));
            icmd_valid = ($urandom % 2) == 0;
            iwrite_ack = ($urandom % 100) < 35;
            iread_ack  = ($urandom % 100) < 35;
            iread_data = 16'($urandom);
            step();
            exp_cnt = 4'(m_q.size());
            total_cnt++; if (ocount !== exp_cnt || ocmd_ready !== (m_q.size() != DEPTH)) $display("FAIL rnd_count[%0d]: got %0d/%b want %0d/%b", n, ocount, ocmd_ready, exp_cnt, m_q.size() != DEPTH); else pass_cnt++;
            total_cnt++; if (owrite_req !== (m_busy && m_cur.we) || oread_req !== (m_busy && !m_cur.we) || obusy !== m_busy) $display("FAIL rnd_req[%0d]: got wr=%b rd=%b busy=%b want %b/%b/%b", n, owrite_req, oread_req, obusy, m_busy && m_cur.we, m_busy && !m_cur.we, m_busy); else pass_cnt++;
            total_cnt++; if (owrite_address !== m_wa || owrite_data !== m_wd || oread_address !== m_ra) $display("FAIL rnd_bus[%0d]: got %h/%h/%h want %h/%h/%h", n, owrite_address, owrite_data, oread_address, m_wa, m_wd, m_ra); else pass_cnt++;
            total_cnt++; if (orsp_valid !== m_rsp_v || orsp_data !== m_rsp_d || oerror !== m_err) $display("FAIL rnd_rsp[%0d]: got v=%b d=%h err=%b want %b/%h/%b", n, orsp_valid, orsp_data, oerror, m_rsp_v, m_rsp_d, m_err); else pass_cnt++;
        end
        icmd_valid = 1'b0; iwrite_ack = 1'b0; iread_ack = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        ireset = 1'b1; step(); ireset = 1'b0;
        set_cmd(1'b0, 22'h12_3456, 16'h0000); step();
        for (int i = 0; i < 4; i++) begin set_cmd(i[0], 22'(22'h00_0C00 + i), 16'(16'h3330 + i)); step(); end
        icmd_valid = 1'b0;
        total_cnt++; if (oread_req !== 1'b1 || ocount !== 4'd4) $display("FAIL rst_pre: got req=%b count=%0d want 1/4", oread_req, ocount); else pass_cnt++;
        ireset = 1'b1; step(); ireset = 1'b0;
        total_cnt++; if ({owrite_req, oread_req, orsp_valid, obusy, oerror} !== 5'b0 || ocount !== 4'd0 || ocmd_ready !== 1'b1) $display("FAIL rst_mid: got flags=%b count=%0d ready=%b want 00000/0/1", {owrite_req, oread_req, orsp_valid, obusy, oerror}, ocount, ocmd_ready); else pass_cnt++;
        total_cnt++; if ({owrite_address, owrite_data, oread_address, orsp_data} !== 76'b0) $display("FAIL rst_buses: got %h want 0", {owrite_address, owrite_data, oread_address, orsp_data}); else pass_cnt++;
        iread_data = 16'hDEAD; iread_ack = 1'b1; step(); iread_ack = 1'b0;
        total_cnt++; if (orsp_valid !== 1'b0 || obusy !== 1'b0 || oread_req !== 1'b0) $display("FAIL rst_late_ack: got v=%b busy=%b req=%b want 0/0/0", orsp_valid, obusy, oread_req); else pass_cnt++;
    endtask

    initial begin
        ireset = 1'b1; icmd_valid = 1'b0; icmd_we = 1'b0; icmd_address = '0; icmd_wdata = '0;
        iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_full_queue();
        test_push_pop();
        test_timeout();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
